// File: rtl/edge_detector_pkg.sv
// Shared types and default sizes for the Sobel convolver and its magnitude unit.
package edge_detector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int PIX_W   = 8;
  localparam int K_W     = 3;
  localparam int ACC_W   = 12;
  localparam int TAPS    = 9;
  localparam int PIX_MAX = 255;

endpackage

// File: rtl/edge_detector_mag.sv
// Combinational |Gx|+|Gy| reduction to an output pixel.
// EDGE_THRESHOLD_EN: when defined, binarise against THRESHOLD instead of saturating.
module edge_detector_mag
  import edge_detector_pkg::*;
#(
  parameter int MAG_ACC_W = edge_detector_pkg::ACC_W,
  parameter int MAG_PIX_W = edge_detector_pkg::PIX_W,
  parameter int THRESHOLD = 64
) (
  input  logic signed [MAG_ACC_W-1:0] gx,
  input  logic signed [MAG_ACC_W-1:0] gy,
  output logic        [MAG_PIX_W-1:0] mag
);

  logic [MAG_ACC_W-1:0] abs_x, abs_y;
  logic [MAG_ACC_W:0]   sum;

  // Absolute values are taken as unsigned so the most negative code still fits.
  always_comb begin
    abs_x = gx[MAG_ACC_W-1] ? MAG_ACC_W'(-gx) : MAG_ACC_W'(gx);
    abs_y = gy[MAG_ACC_W-1] ? MAG_ACC_W'(-gy) : MAG_ACC_W'(gy);
    sum   = {1'b0, abs_x} + {1'b0, abs_y};
`ifdef EDGE_THRESHOLD_EN
    mag = (sum >= (MAG_ACC_W+1)'(THRESHOLD)) ? {MAG_PIX_W{1'b1}} : '0;
`else
    mag = (sum > (MAG_ACC_W+1)'({MAG_PIX_W{1'b1}})) ? {MAG_PIX_W{1'b1}} : sum[MAG_PIX_W-1:0];
`endif
  end

endmodule

// File: rtl/edge_detector_convolver.sv
// Sequential 3x3 Sobel convolver: walks the nine taps row-major, MACs Kx/Ky
// against the returned pixel, then presents |Gx|+|Gy| on a valid/ready port.
// EDGE_THRESHOLD_EN: when defined, the result is binarised against THRESHOLD.
module edge_detector_convolver #(
  parameter int PIX_W     = edge_detector_pkg::PIX_W,
  parameter int K_W       = edge_detector_pkg::K_W,
  parameter int ACC_W     = edge_detector_pkg::ACC_W,
  parameter int THRESHOLD = 64
) (
  input  logic             Clk_i,
  input  logic             Rstn_i,
  input  logic             Start_i,
  output logic             Busy_o,
  output logic [2:0]       Xindex_o,
  output logic [2:0]       Yindex_o,
  input  logic [PIX_W-1:0] Pixel_i,
  input  logic [K_W-1:0]   Kx_i,
  input  logic [K_W-1:0]   Ky_i,
  output logic             Valid_o,
  input  logic             Ready_i,
  output logic [PIX_W-1:0] Pixel_o
);

  import edge_detector_pkg::*;

  state_t state, state_nxt;
  logic [3:0] tap;
  logic signed [ACC_W-1:0] gx, gy, gx_nxt, gy_nxt;
  logic signed [ACC_W-1:0] kx_ext, ky_ext, pix_ext;
  logic [PIX_W-1:0] mag_res;
  logic last_tap;

  assign last_tap = (tap == 4'(TAPS-1));
  assign Busy_o   = (state != IDLE);
  assign Valid_o  = (state == DONE);

  // Tap products; Sobel coefficients bound the sums to +/-1020, inside ACC_W.
  always_comb begin
    kx_ext  = ACC_W'($signed(Kx_i));
    ky_ext  = ACC_W'($signed(Ky_i));
    pix_ext = $signed(ACC_W'({1'b0, Pixel_i}));
    gx_nxt  = gx + kx_ext * pix_ext;
    gy_nxt  = gy + ky_ext * pix_ext;
  end

  // Magnitude is taken from the sums that include the current tap, so the
  // final tap lands in the result register on the same edge as DONE entry.
  edge_detector_mag #(
    .MAG_ACC_W (ACC_W),
    .MAG_PIX_W (PIX_W),
    .THRESHOLD (THRESHOLD)
  ) u_mag (
    .gx  (gx_nxt),
    .gy  (gy_nxt),
    .mag (mag_res)
  );

  // State register.
  always_ff @(posedge Clk_i or negedge Rstn_i) begin
    if (!Rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state: start only from IDLE, nine taps, then hold until accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start_i)  state_nxt = ACCUM;
      ACCUM:   if (last_tap) state_nxt = DONE;
      DONE:    if (Ready_i)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Tap walk, accumulators and result register.
  always_ff @(posedge Clk_i or negedge Rstn_i) begin
    if (!Rstn_i) begin
      tap      <= '0;
      Xindex_o <= '0;
      Yindex_o <= '0;
      gx       <= '0;
      gy       <= '0;
      Pixel_o  <= '0;
    end else begin
      case (state)
        IDLE: if (Start_i) begin
          tap      <= '0;
          Xindex_o <= '0;
          Yindex_o <= '0;
          gx       <= '0;
          gy       <= '0;
        end
        ACCUM: begin
          gx <= gx_nxt;
          gy <= gy_nxt;
          if (last_tap) begin
            tap      <= '0;
            Xindex_o <= '0;
            Yindex_o <= '0;
            Pixel_o  <= mag_res;
          end else begin
            tap <= tap + 4'd1;
            if (Yindex_o == 3'd2) begin
              Yindex_o <= '0;
              Xindex_o <= Xindex_o + 3'd1;
            end else begin
              Yindex_o <= Yindex_o + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_detector_convolver.sv
// Scoreboard bench: stimulus pushes model results, a monitor pops on handshake.
module tb_edge_detector_convolver;

  logic       Clk_i = 1'b0;
  logic       Rstn_i = 1'b0;
  logic       Start_i = 1'b0;
  logic       Ready_i = 1'b1;
  logic       Busy_o, Valid_o;
  logic [2:0] Xindex_o, Yindex_o;
  logic [7:0] Pixel_i, Pixel_o;
  logic [2:0] Kx_i, Ky_i;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int win[3][3];
  int kx[3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  int ky[3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

  edge_detector_convolver #(
    .PIX_W(8), .K_W(3), .ACC_W(12), .THRESHOLD(64)
  ) dut (
    .Clk_i(Clk_i), .Rstn_i(Rstn_i), .Start_i(Start_i), .Busy_o(Busy_o),
    .Xindex_o(Xindex_o), .Yindex_o(Yindex_o), .Pixel_i(Pixel_i),
    .Kx_i(Kx_i), .Ky_i(Ky_i), .Valid_o(Valid_o), .Ready_i(Ready_i),
    .Pixel_o(Pixel_o)
  );

  always #5 Clk_i = ~Clk_i;

  // Window buffer and kernel block neighbours: combinational lookups.
  always_comb begin
    Pixel_i = '0;
    Kx_i    = '0;
    Ky_i    = '0;
    if (Xindex_o < 3 && Yindex_o < 3) begin
      Pixel_i = 8'(win[Xindex_o][Yindex_o]);
      Kx_i    = 3'(kx[Xindex_o][Yindex_o]);
      Ky_i    = 3'(ky[Xindex_o][Yindex_o]);
    end
  end

  function automatic int model();
    int gx = 0, gy = 0, m;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        gx += kx[r][c] * win[r][c];
        gy += ky[r][c] * win[r][c];
      end
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef EDGE_THRESHOLD_EN
    return (m >= 64) ? 255 : 0;
`else
    return (m > 255) ? 255 : m;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_cols(input int l, input int m, input int r);
    for (int i = 0; i < 3; i++) begin
      win[i][0] = l; win[i][1] = m; win[i][2] = r;
    end
  endtask

  // Monitor: compare the held result on every accepting cycle.
  always @(negedge Clk_i) begin
    if (Rstn_i && Valid_o && Ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result got %0d expected none", Pixel_o);
      end else begin
        chk("result", int'(Pixel_o), exp_q.pop_front());
      end
    end
  end

  // One convolution; hold = cycles of backpressure after Valid_o rises.
  task automatic conv(input int hold);
    int e;
    @(negedge Clk_i);
    chk("idle_before_start", int'(Busy_o), 0);
    exp_q.push_back(model());
    Ready_i = (hold == 0);
    Start_i = 1'b1;
    @(posedge Clk_i);
    #1 Start_i = 1'b0;
    for (int t = 0; t < 9; t++) begin
      @(negedge Clk_i);
      chk("xindex", int'(Xindex_o), t / 3);
      chk("yindex", int'(Yindex_o), t % 3);
      chk("busy_accum", int'(Busy_o), 1);
      chk("valid_early", int'(Valid_o), 0);
    end
    @(negedge Clk_i);
    chk("valid_latency", int'(Valid_o), 1);
    chk("idx_done_x", int'(Xindex_o), 0);
    if (hold > 0) begin
      e = exp_q[0];
      for (int h = 0; h < hold; h++) begin
        chk("bp_valid", int'(Valid_o), 1);
        chk("bp_pixel", int'(Pixel_o), e);
        chk("bp_busy", int'(Busy_o), 1);
        Start_i = (h == 1);
        @(negedge Clk_i);
      end
      Start_i = 1'b0;
      @(posedge Clk_i);
      #1 Ready_i = 1'b1;
      @(negedge Clk_i);
    end
    @(negedge Clk_i);
    chk("idle_after_hs_busy", int'(Busy_o), 0);
    chk("idle_after_hs_valid", int'(Valid_o), 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) win[i][j] = 0;
    #12;
    chk("rst_busy", int'(Busy_o), 0);
    chk("rst_valid", int'(Valid_o), 0);
    chk("rst_pixel", int'(Pixel_o), 0);
    chk("rst_x", int'(Xindex_o), 0);
    chk("rst_y", int'(Yindex_o), 0);
    @(posedge Clk_i);
    #1 Rstn_i = 1'b1;

    set_cols(100, 100, 100); conv(0);   // flat
    set_cols(0, 128, 255);   conv(0);   // strong edge
    set_cols(10, 15, 20);    conv(0);   // weak edge
    set_cols(10, 15, 20);    conv(5);   // backpressure with ignored start
    repeat (3) begin
      @(negedge Clk_i);
      chk("start_ignored_in_done", int'(Busy_o), 0);
    end

    // Reset during tap 4.
    set_cols(0, 128, 255);
    @(negedge Clk_i);
    exp_q.push_back(model());
    Start_i = 1'b1;
    @(posedge Clk_i);
    #1 Start_i = 1'b0;
    repeat (5) @(negedge Clk_i);
    chk("tap4_x", int'(Xindex_o), 1);
    chk("tap4_y", int'(Yindex_o), 1);
    Rstn_i = 1'b0;
    #1;
    chk("mid_rst_busy", int'(Busy_o), 0);
    chk("mid_rst_valid", int'(Valid_o), 0);
    chk("mid_rst_pixel", int'(Pixel_o), 0);
    chk("mid_rst_x", int'(Xindex_o), 0);
    chk("mid_rst_y", int'(Yindex_o), 0);
    exp_q.delete();
    @(posedge Clk_i);
    #1 Rstn_i = 1'b1;
    set_cols(10, 15, 20); conv(0);

    // Random windows with random backpressure.
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) win[i][j] = int'($urandom_range(0, 255));
      conv(int'($urandom_range(0, 3)));
    end

    @(negedge Clk_i);
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
